// File: rtl/svc_rv_dmem_bridge_pkg.sv
// Shared types and constants for the svc_rv dmem-to-bus bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package svc_rv_dmem_bridge_pkg;

  // Bridge access sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  // Load data handed back to the core when a read response never arrives
  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/svc_rv_dmem_bridge.sv
// Bridges the core dmem port to a single-outstanding valid/ready bus.
// Latency: store 2 cycles best case; load 3 cycles to stall release, data 1 cycle after.
// Backpressure: dmem_stall holds the core until the bus accepts a store or a load completes.
module svc_rv_dmem_bridge
  import svc_rv_dmem_bridge_pkg::*;
#(
  parameter int          AW           = 32,
  parameter int          TIMEOUT      = 64,
  parameter logic [31:0] TIMEOUT_DATA = DEFAULT_TIMEOUT_DATA
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          dmem_ren,
  input  logic [AW-1:0] dmem_raddr,
  output logic [31:0]   dmem_rdata,
  input  logic          dmem_we,
  input  logic [AW-1:0] dmem_waddr,
  input  logic [31:0]   dmem_wdata,
  input  logic [3:0]    dmem_wstrb,
  output logic          dmem_stall,

  output logic          m_req_valid,
  input  logic          m_req_ready,
  output logic          m_req_we,
  output logic [AW-1:0] m_req_addr,
  output logic [31:0]   m_req_wdata,
  output logic [3:0]    m_req_wstrb,
  input  logic          m_rsp_valid,
  input  logic [31:0]   m_rsp_rdata,

  output logic          err_timeout,
  output logic          err_unexpected
);

  // A zero TIMEOUT disables the watchdog; keep a 1-bit counter so widths stay legal.
  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam bit            TMO_EN   = (TIMEOUT > 0);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;

  logic core_req;
  logic wr_hs;
  logic rd_hs;
  logic rsp_take;
  logic tmo_hit;

  assign core_req = dmem_we | dmem_ren;
  assign wr_hs    = (state == REQ) & m_req_ready & m_req_we;
  assign rd_hs    = (state == REQ) & m_req_ready & ~m_req_we;
  // A response arriving alongside the read handshake is not for this access yet.
  assign rsp_take = (state == WAIT_RSP) & m_rsp_valid;
  // Response on the final watchdog cycle wins over the timeout.
  assign tmo_hit  = TMO_EN & (state == WAIT_RSP) & ~m_rsp_valid & (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and pipeline hold; stall drops exactly on the completing cycle
  always_comb begin
    state_nxt  = state;
    dmem_stall = 1'b0;
    case (state)
      IDLE: begin
        if (core_req) begin
          dmem_stall = 1'b1;
          state_nxt  = REQ;
        end
      end
      REQ: begin
        dmem_stall = ~wr_hs;
        if (wr_hs) begin
          state_nxt = IDLE;
        end else if (rd_hs) begin
          state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_take || tmo_hit) begin
          state_nxt = IDLE;
        end else begin
          dmem_stall = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture the core request (store wins) and hold it on the bus until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req_valid <= 1'b0;
      m_req_we    <= 1'b0;
      m_req_addr  <= '0;
      m_req_wdata <= '0;
      m_req_wstrb <= '0;
    end else if (state == IDLE && core_req) begin
      m_req_valid <= 1'b1;
      m_req_we    <= dmem_we;
      m_req_addr  <= dmem_we ? dmem_waddr : dmem_raddr;
      m_req_wdata <= dmem_we ? dmem_wdata : 32'h0;
      m_req_wstrb <= dmem_we ? dmem_wstrb : 4'b0000;
    end else if (state == REQ && m_req_ready) begin
      m_req_valid <= 1'b0;
    end
  end

  // Watchdog counter, restarted on every entry to WAIT_RSP so it never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rd_hs) begin
      cnt <= '0;
    end else if (state == WAIT_RSP) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Load data register and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_rdata     <= 32'h0;
      err_timeout    <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      if (rsp_take) begin
        dmem_rdata <= m_rsp_rdata;
      end else if (tmo_hit) begin
        dmem_rdata  <= TIMEOUT_DATA;
        err_timeout <= 1'b1;
      end
      if (m_rsp_valid && state != WAIT_RSP) begin
        err_unexpected <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_svc_rv_dmem_bridge.sv
// Self-checking bench for svc_rv_dmem_bridge: directed scenarios then randomized accesses
// scored against a transaction-level model (completion cycle and returned data per access).
module tb_svc_rv_dmem_bridge;

  localparam int          TMO     = 4;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dmem_ren = 1'b0;
  logic [31:0] dmem_raddr = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_we = 1'b0;
  logic [31:0] dmem_waddr = '0;
  logic [31:0] dmem_wdata = '0;
  logic [3:0]  dmem_wstrb = '0;
  logic        dmem_stall;
  logic        m_req_valid;
  logic        m_req_ready = 1'b0;
  logic        m_req_we;
  logic [31:0] m_req_addr;
  logic [31:0] m_req_wdata;
  logic [3:0]  m_req_wstrb;
  logic        m_rsp_valid = 1'b0;
  logic [31:0] m_rsp_rdata = '0;
  logic        err_timeout;
  logic        err_unexpected;

  int tests = 0;
  int fails = 0;

  // Reference state: last load data delivered and sticky error expectations
  logic [31:0] model_rdata = 32'h0;
  logic        model_to    = 1'b0;
  logic        model_unexp = 1'b0;

  svc_rv_dmem_bridge #(.AW(32), .TIMEOUT(TMO), .TIMEOUT_DATA(TO_DATA)) dut (
    .clk(clk), .rst(rst),
    .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
    .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_stall(dmem_stall),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata),
    .err_timeout(err_timeout), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bridge status that must hold whenever it is idle between accesses
  task automatic chk_idle_state(input string tag);
    chk({tag, "_rdata"}, dmem_rdata, model_rdata);
    chk({tag, "_err_to"}, 32'(err_timeout), 32'(model_to));
    chk({tag, "_err_unexp"}, 32'(err_unexpected), 32'(model_unexp));
    chk({tag, "_req_valid"}, 32'(m_req_valid), 32'h0);
  endtask

  // Idle cycles with no core request and an optional stray response
  task automatic idle(input int n, input bit stray_rsp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dmem_we     = 1'b0;
      dmem_ren    = 1'b0;
      m_req_ready = 1'b0;
      m_rsp_valid = stray_rsp;
      m_rsp_rdata = $urandom;
      #1;
      chk("idle_stall", 32'(dmem_stall), 32'h0);
      chk_idle_state("idle");
      if (stray_rsp) model_unexp = 1'b1;
    end
    @(negedge clk);
    m_rsp_valid = 1'b0;
  endtask

  // One core access. Bus accepts rdy_dly cycles after the request is first
  // presented; a read response comes rsp_dly cycles after the handshake.
  task automatic access(input bit w, input bit also_ren, input logic [31:0] wa,
                        input logic [31:0] ra, input logic [31:0] wd, input logic [3:0] s,
                        input int rdy_dly, input int rsp_dly, input logic [31:0] rd);
    int          h;
    int          c;
    bit          to;
    logic [31:0] exp_d;
    h     = 1 + rdy_dly;
    to    = !w && (rsp_dly > TMO);
    c     = w ? h : h + (to ? TMO : rsp_dly);
    exp_d = w ? model_rdata : (to ? TO_DATA : rd);
    for (int k = 0; k <= c; k++) begin
      @(negedge clk);
      if (k == 0) begin
        dmem_we    = w;
        dmem_ren   = w ? also_ren : 1'b1;
        dmem_waddr = wa;
        dmem_raddr = ra;
        dmem_wdata = wd;
        dmem_wstrb = s;
      end
      m_req_ready = (k == h);
      m_rsp_valid = !w && (k == h + rsp_dly);
      m_rsp_rdata = m_rsp_valid ? rd : $urandom;
      #1;
      if (k == 0) chk_idle_state("start");
      chk($sformatf("stall_k%0d", k), 32'(dmem_stall), 32'(k != c));
      if (k >= 1 && k <= h) begin
        chk("req_valid", 32'(m_req_valid), 32'h1);
        chk("req_we", 32'(m_req_we), 32'(w));
        chk("req_addr", m_req_addr, w ? wa : ra);
        chk("req_wstrb", 32'(m_req_wstrb), w ? 32'(s) : 32'h0);
        if (w) chk("req_wdata", m_req_wdata, wd);
      end else if (k > h) begin
        chk("req_dropped", 32'(m_req_valid), 32'h0);
      end
    end
    model_rdata = exp_d;
    if (to) model_to = 1'b1;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    #1;
    chk("rst_stall", 32'(dmem_stall), 32'h0);
    chk("rst_req_we", 32'(m_req_we), 32'h0);
    chk("rst_req_addr", m_req_addr, 32'h0);
    chk("rst_req_wdata", m_req_wdata, 32'h0);
    chk("rst_req_wstrb", 32'(m_req_wstrb), 32'h0);
    chk_idle_state("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Two-cycle store, bus always ready
    access(1'b1, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 4'b0011, 0, 1, 32'h0);
    idle(1, 1'b0);

    // Load with a slow bus and a slow response; data must survive a following store
    access(1'b0, 1'b0, 32'h0, 32'h80, 32'h0, 4'h0, 2, 3, 32'hCAFE_F00D);
    access(1'b1, 1'b1, 32'h44, 32'h88, 32'hAAAA_5555, 4'b1111, 0, 1, 32'h0);
    idle(1, 1'b0);

    // Response on the last watchdog cycle wins, no error
    access(1'b0, 1'b0, 32'h0, 32'hC0, 32'h0, 4'h0, 0, TMO, 32'h0BAD_CAFE);
    idle(1, 1'b0);

    // No response at all: forced completion, error sticks
    access(1'b0, 1'b0, 32'h0, 32'hC4, 32'h0, 4'h0, 1, 99, 32'h0);
    idle(2, 1'b0);

    // Stray response while idle
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Asynchronous reset in the middle of a load
    @(negedge clk);
    dmem_ren = 1'b1; dmem_we = 1'b0; dmem_raddr = 32'h100; m_req_ready = 1'b0;
    @(negedge clk);
    m_req_ready = 1'b1;
    @(negedge clk);
    m_req_ready = 1'b0;
    #1;
    chk("mid_stall", 32'(dmem_stall), 32'h1);
    #1;
    rst = 1'b1;
    dmem_ren = 1'b0;
    #1;
    model_rdata = 32'h0; model_to = 1'b0; model_unexp = 1'b0;
    chk("arst_stall", 32'(dmem_stall), 32'h0);
    chk("arst_req_addr", m_req_addr, 32'h0);
    chk("arst_req_we", 32'(m_req_we), 32'h0);
    chk_idle_state("arst");
    @(negedge clk);
    rst = 1'b0;
    idle(1, 1'b1);
    idle(1, 1'b0);
    access(1'b0, 1'b0, 32'h0, 32'h104, 32'h0, 4'h0, 0, 1, 32'h7777_0001);
    idle(1, 1'b0);

    // Randomized accesses, sometimes back-to-back
    for (int i = 0; i < 40; i++) begin
      bit w;
      w = 1'($urandom_range(0, 1));
      access(w, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(1, 6), $urandom);
      if ($urandom_range(0, 2) == 0) idle(1, 1'b0);
    end
    idle(1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
